// File: rtl/gate_trainer_pkg.sv
// Shared definitions for the logic-gate unit and its self-test sequencer:
// function select encodings, golden truth tables and sequencer states.
package gate_trainer_pkg;

    localparam int NUM_GATES = 7;

    localparam logic [2:0] SEL_AND  = 3'd0;
    localparam logic [2:0] SEL_OR   = 3'd1;
    localparam logic [2:0] SEL_NOT  = 3'd2;
    localparam logic [2:0] SEL_NAND = 3'd3;
    localparam logic [2:0] SEL_NOR  = 3'd4;
    localparam logic [2:0] SEL_XOR  = 3'd5;
    localparam logic [2:0] SEL_XNOR = 3'd6;

    // Truth tables indexed by {b,a}; bit 3 is the a=1,b=1 result.
    localparam logic [3:0] GOLDEN_TT [0:NUM_GATES-1] = '{
        4'b1000,  // AND
        4'b1110,  // OR
        4'b0101,  // NOT (of a)
        4'b0111,  // NAND
        4'b0001,  // NOR
        4'b0110,  // XOR
        4'b1001   // XNOR
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/gate_selftest_sequencer.sv
// Self-test sequencer: sweeps every gate function over all four input
// pairs, builds each truth table from gate_y and flags per-gate mismatches.
module gate_selftest_sequencer
    import gate_trainer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       gate_y,
    output logic       gate_a,
    output logic       gate_b,
    output logic [2:0] gate_sel,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] fail_mask,
    output logic [3:0] tt_last
);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    seq_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_ab;
    logic [2:0]       r_sel;
    logic [3:0]       r_cap;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [6:0]       r_fail_mask;
    logic [3:0]       r_tt_last;

    logic [3:0]       w_tt;
    logic             w_mismatch;
    logic [6:0]       w_fail_next;

    // Completed table as it will look once this cycle's sample lands.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_tt       = r_cap;
        w_tt[r_ab] = gate_y;
        w_mismatch  = (w_tt != GOLDEN_TT[r_sel]);
        w_fail_next = r_fail_mask | (w_mismatch ? (7'b1 << r_sel) : 7'b0);
    end

    // Sequencer FSM with settle counter; all outputs are registered here.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ab        <= 2'b00;
            r_sel       <= SEL_AND;
            r_cap       <= 4'b0000;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_mask <= 7'b0;
            r_tt_last   <= 4'b0000;
        end else if (abort && (r_state != ST_IDLE)) begin
            // Partial fail_mask and the last captured table are kept for inspection.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_ab    <= 2'b00;
            r_sel   <= SEL_AND;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state     <= ST_SETTLE;
                        r_cnt       <= CNT_RELOAD;
                        r_ab        <= 2'b00;
                        r_sel       <= SEL_AND;
                        r_cap       <= 4'b0000;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_fail_mask <= 7'b0;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    r_cap[r_ab] <= gate_y;
                    if (r_ab != 2'b11) begin
                        r_ab    <= r_ab + 2'b01;
                        r_cnt   <= CNT_RELOAD;
                        r_state <= ST_SETTLE;
                    end else begin
                        r_fail_mask <= w_fail_next;
                        r_tt_last   <= w_tt;
                        if (r_sel == SEL_XNOR) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_fail_next == 7'b0);
                        end else begin
                            r_sel   <= r_sel + 3'd1;
                            r_ab    <= 2'b00;
                            r_cnt   <= CNT_RELOAD;
                            r_state <= ST_SETTLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gate_a    = r_ab[0];
    assign gate_b    = r_ab[1];
    assign gate_sel  = r_sel;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_mask = r_fail_mask;
    assign tt_last   = r_tt_last;

endmodule

// File: tb/tb_gate_selftest_sequencer.sv
// Bench for gate_selftest_sequencer: a behavioural gate unit with selectable
// faults feeds the DUT; expected sweep results are queued at start and
// compared when done rises.
module tb_gate_selftest_sequencer;

    localparam int SETTLE    = 2;
    // Edges counted with the start-sampling edge as edge 1.
    localparam int DONE_EDGE = 28 * (SETTLE + 1) + 1;
    localparam int MAX_EDGES = 200;

    localparam int MODE_OK    = 0;
    localparam int MODE_XOR0  = 1;
    localparam int MODE_STUCK = 2;

    typedef struct {
        logic [6:0] mask;
        logic       pass;
        logic [3:0] tt;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       gate_y;
    logic       gate_a;
    logic       gate_b;
    logic [2:0] gate_sel;
    logic       busy;
    logic       done;
    logic       pass;
    logic [6:0] fail_mask;
    logic [3:0] tt_last;

    int   fault_mode;
    int   n_checks;
    int   n_pass;
    exp_t sb_q[$];

    gate_selftest_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .gate_y    (gate_y),
        .gate_a    (gate_a),
        .gate_b    (gate_b),
        .gate_sel  (gate_sel),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_mask (fail_mask),
        .tt_last   (tt_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural gate unit with optional fault injection.
    function automatic logic model_y(input logic [2:0] sel, input logic a, input logic b, input int mode);
        logic y;
        case (sel)
            3'd0:    y = a & b;
            3'd1:    y = a | b;
            3'd2:    y = ~a;
            3'd3:    y = ~(a & b);
            3'd4:    y = ~(a | b);
            3'd5:    y = a ^ b;
            3'd6:    y = ~(a ^ b);
            default: y = 1'b0;
        endcase
        if (mode == MODE_XOR0 && sel == 3'd5) y = 1'b0;
        if (mode == MODE_STUCK) y = 1'b1;
        return y;
    endfunction

    assign gate_y = model_y(gate_sel, gate_a, gate_b, fault_mode);

    function automatic logic [3:0] table_of(input int sel, input int mode);
        logic [3:0] t;
        t = 4'b0000;
        for (int ab = 0; ab < 4; ab++) begin
            t[ab] = model_y(3'(sel), ab[0], ab[1], mode);
        end
        return t;
    endfunction

    // Fail mask after the first n_gates gates have been compared.
    function automatic logic [6:0] mask_after(input int mode, input int n_gates);
        logic [6:0] m;
        m = 7'b0;
        for (int k = 0; k < n_gates; k++) begin
            if (table_of(k, mode) != table_of(k, MODE_OK)) m[k] = 1'b1;
        end
        return m;
    endfunction

    function automatic exp_t expect_sweep(input int mode);
        exp_t e;
        e.mask = mask_after(mode, 7);
        e.pass = (e.mask == 7'b0);
        e.tt   = table_of(6, mode);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full sweep with optional extra start pulses at the given edges (0 = none).
    task automatic run_sweep(input string name, input int mode, input int e1, input int e2);
        exp_t exp_r;
        bit   got_done;
        int   bad_seq;
        fault_mode = mode;
        sb_q.push_back(expect_sweep(mode));
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL %s_busy_after_start: busy=%b done=%b, required busy=1 done=0", name, busy, done);
        else n_pass++;
        got_done = 1'b0;
        bad_seq  = 0;
        for (int n = 2; n <= MAX_EDGES && !got_done; n++) begin
            start = ((n == e1) || (n == e2));
            step();
            start = 1'b0;
            if (gate_sel > 3'd6) bad_seq++;
            if (done === 1'b1) begin
                got_done = 1'b1;
                n_checks++;
                if (n != DONE_EDGE)
                    $display("FAIL %s_done_edge: done at edge %0d, required %0d", name, n, DONE_EDGE);
                else n_pass++;
                exp_r = sb_q.pop_front();
                n_checks++;
                if (fail_mask !== exp_r.mask)
                    $display("FAIL %s_fail_mask: got %b, required %b", name, fail_mask, exp_r.mask);
                else n_pass++;
                n_checks++;
                if (pass !== exp_r.pass)
                    $display("FAIL %s_pass: got %b, required %b", name, pass, exp_r.pass);
                else n_pass++;
                n_checks++;
                if (tt_last !== exp_r.tt)
                    $display("FAIL %s_tt_last: got %b, required %b", name, tt_last, exp_r.tt);
                else n_pass++;
                n_checks++;
                if (busy !== 1'b0)
                    $display("FAIL %s_busy_at_done: got %b, required 0", name, busy);
                else n_pass++;
            end else if (busy !== 1'b1) begin
                bad_seq++;
            end
        end
        n_checks++;
        if (!got_done) begin
            $display("FAIL %s_timeout: done not seen within %0d edges, required by edge %0d", name, MAX_EDGES, DONE_EDGE);
            void'(sb_q.pop_front());
        end else n_pass++;
        n_checks++;
        if (bad_seq != 0)
            $display("FAIL %s_sweep_status: %0d cycles with busy low or gate_sel>6, required 0", name, bad_seq);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({gate_a, gate_b, gate_sel, busy, done, pass, fail_mask, tt_last} !== 19'b0)
            $display("FAIL reset_outputs: a=%b b=%b sel=%0d busy=%b done=%b pass=%b mask=%b tt=%b, required all 0",
                     gate_a, gate_b, gate_sel, busy, done, pass, fail_mask, tt_last);
        else n_pass++;
        rst = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_idle_hold: busy=%b done=%b, required 0 0", busy, done);
        else n_pass++;
    endtask

    task automatic test_normal_sweep();
        run_sweep("normal", MODE_OK, 0, 0);
    endtask

    task automatic test_xor_fault();
        run_sweep("xor_fault", MODE_XOR0, 0, 0);
    endtask

    task automatic test_stuck_high();
        run_sweep("stuck_high", MODE_STUCK, 0, 0);
    endtask

    task automatic test_abort();
        logic [6:0] exp_mask;
        fault_mode = MODE_STUCK;
        start = 1'b1;
        step();                      // edge 1
        start = 1'b0;
        for (int n = 2; n < 40; n++) step();
        abort = 1'b1;
        step();                      // edge 40
        abort = 1'b0;
        // Gates finish at edge 12*(k+1)+1; three are complete before edge 40.
        exp_mask = mask_after(MODE_STUCK, 3);
        n_checks++;
        if ({busy, done, pass, gate_sel, gate_a, gate_b} !== 8'b0)
            $display("FAIL abort_outputs: busy=%b done=%b pass=%b sel=%0d a=%b b=%b, required all 0",
                     busy, done, pass, gate_sel, gate_a, gate_b);
        else n_pass++;
        n_checks++;
        if (fail_mask !== exp_mask)
            $display("FAIL abort_partial_mask: got %b, required %b", fail_mask, exp_mask);
        else n_pass++;
        // Abort while idle must leave everything alone.
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0 || gate_sel !== 3'd0 || fail_mask !== exp_mask)
            $display("FAIL abort_in_idle: busy=%b sel=%0d mask=%b, required 0 0 %b", busy, gate_sel, fail_mask, exp_mask);
        else n_pass++;
        run_sweep("after_abort", MODE_OK, 0, 0);
    endtask

    task automatic test_extra_start();
        run_sweep("extra_start", MODE_OK, 10, 50);
    endtask

    task automatic test_start_abort_in_done();
        n_checks++;
        if (done !== 1'b1)
            $display("FAIL done_level_held: done=%b, required 1", done);
        else n_pass++;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || pass !== 1'b0)
            $display("FAIL start_abort_done: done=%b busy=%b pass=%b, required 0 0 0", done, busy, pass);
        else n_pass++;
        step();
        step();
        n_checks++;
        if (busy !== 1'b0 || gate_sel !== 3'd0 || gate_a !== 1'b0)
            $display("FAIL start_abort_no_sweep: busy=%b sel=%0d a=%b, required 0 0 0", busy, gate_sel, gate_a);
        else n_pass++;
    endtask

    task automatic test_reset_mid_sweep();
        fault_mode = MODE_STUCK;
        start = 1'b1;
        step();                      // edge 1
        start = 1'b0;
        for (int n = 2; n < 30; n++) step();
        rst = 1'b1;
        step();                      // edge 30
        rst = 1'b0;
        n_checks++;
        if ({gate_a, gate_b, gate_sel, busy, done, pass, fail_mask, tt_last} !== 19'b0)
            $display("FAIL reset_mid_sweep: a=%b b=%b sel=%0d busy=%b done=%b pass=%b mask=%b tt=%b, required all 0",
                     gate_a, gate_b, gate_sel, busy, done, pass, fail_mask, tt_last);
        else n_pass++;
        step();
        n_checks++;
        if (busy !== 1'b0 || gate_sel !== 3'd0)
            $display("FAIL reset_mid_sweep_idle: busy=%b sel=%0d, required 0 0", busy, gate_sel);
        else n_pass++;
        run_sweep("after_reset", MODE_OK, 0, 0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        fault_mode = MODE_OK;
        n_checks   = 0;
        n_pass     = 0;
        test_reset();
        test_normal_sweep();
        test_xor_fault();
        test_stuck_high();
        test_abort();
        test_extra_start();
        test_start_abort_in_done();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
